a2d_scan_intf: RTL and testbench

Parametrised A2D converter interface that converts one requested channel or continuously scans channels 0..NUM_CHNL-1 round-robin over a 16-bit SPI link. Each conversion is a two-frame transaction: a command frame followed by a read frame. Results are output on a completion pulse and kept in a per-channel result bank that consumers read asynchronously. It sits between the SPI A2D device pins and the equalizer's slider/potentiometer consumers.

---
 rtl/a2d_pkg.sv | 22 ++
 rtl/a2d_spi_xfer.sv | 85 ++++++++
 rtl/a2d_scan_intf.sv | 206 ++++++++++++++++++++
 tb/tb_a2d_scan_intf.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/a2d_pkg.sv
// Shared types and helpers for the A2D scan interface: FSM state encoding,
// SPI frame constants and the A2D command word builder.
`timescale 1ns/1ps
package a2d_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        GAP,
        RD,
        DONE
    } state_t;

    localparam int SPI_FRAME_W = 16;
    localparam int GAP_CYC     = 2;

    // Command word: two zero bits, channel select, then eleven don't-care zeros
    function automatic logic [SPI_FRAME_W-1:0] build_cmd(input logic [2:0] ch);
        return {2'b00, ch, 11'b0};
    endfunction

endpackage

// File: rtl/a2d_spi_xfer.sv
// Single 16-bit SPI frame engine. A frame is a half-period porch with SCLK
// high, then 16 bits of (SCLK low half, SCLK high half). MOSI shifts on
// falling edges after the first, MISO is captured on rising edges, and SS_n
// rises at the end of the last high half. done is high in the final cycle.
`timescale 1ns/1ps
module a2d_spi_xfer
    import a2d_pkg::*;
#(
    parameter int SCLK_DIV = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wrt,
    input  logic [SPI_FRAME_W-1:0] cmd,
    input  logic                   MISO,
    output logic                   SS_n,
    output logic                   SCLK,
    output logic                   MOSI,
    output logic                   done,
    output logic [SPI_FRAME_W-1:0] rd_data
);

    localparam int HALF      = SCLK_DIV / 2;
    localparam int HW        = $clog2(HALF);
    localparam int LAST_HALF = 2 * SPI_FRAME_W;

    logic                   active_reg;
    logic                   ss_n_reg;
    logic                   sclk_reg;
    logic [SPI_FRAME_W-1:0] tx_reg;
    logic [SPI_FRAME_W-1:0] rx_reg;
    logic [HW-1:0]          hcnt_reg;
    logic [5:0]             half_reg;

    logic half_end;
    assign half_end = (hcnt_reg == HW'(HALF - 1));

    // Frame sequencing: half-period counter, SCLK edges, shift registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_reg <= 1'b0;
            ss_n_reg   <= 1'b1;
            sclk_reg   <= 1'b1;
            tx_reg     <= '0;
            rx_reg     <= '0;
            hcnt_reg   <= '0;
            half_reg   <= '0;
        end else if (!active_reg) begin
            if (wrt) begin
                active_reg <= 1'b1;
                ss_n_reg   <= 1'b0;
                sclk_reg   <= 1'b1;
                tx_reg     <= cmd;
                hcnt_reg   <= '0;
                half_reg   <= '0;
            end
        end else if (!half_end) begin
            hcnt_reg <= hcnt_reg + 1'b1;
        end else begin
            hcnt_reg <= '0;
            if (half_reg == 6'(LAST_HALF)) begin
                active_reg <= 1'b0;
                ss_n_reg   <= 1'b1;
            end else begin
                half_reg <= half_reg + 6'd1;
                if (!half_reg[0]) begin
                    // Entering a low half: falling edge; first one keeps bit 15
                    sclk_reg <= 1'b0;
                    if (half_reg != 6'd0)
                        tx_reg <= {tx_reg[SPI_FRAME_W-2:0], 1'b0};
                end else begin
                    sclk_reg <= 1'b1;
                    rx_reg   <= {rx_reg[SPI_FRAME_W-2:0], MISO};
                end
            end
        end
    end

    assign SS_n    = ss_n_reg;
    assign SCLK    = sclk_reg;
    assign MOSI    = tx_reg[SPI_FRAME_W-1];
    assign rd_data = rx_reg;
    assign done    = active_reg && half_end && (half_reg == 6'(LAST_HALF));

endmodule

// File: rtl/a2d_scan_intf.sv
// A2D converter interface: single conversions on request or continuous
// round-robin scan, two SPI frames per conversion, per-channel result bank.
// Scan mode is present only when A2D_SCAN_EN is defined.
`timescale 1ns/1ps
module a2d_scan_intf
    import a2d_pkg::*;
#(
    parameter int NUM_CHNL = 8,
    parameter int RES_W    = 12,
    parameter int SCLK_DIV = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             strt_cnv,
    input  logic [2:0]       chnnl,
    input  logic             scan_en,
    input  logic             MISO,
    output logic             a2d_SS_n,
    output logic             SCLK,
    output logic             MOSI,
    output logic             busy,
    output logic             cnv_cmplt,
    output logic [RES_W-1:0] res,
    output logic [2:0]       res_chnl,
    output logic             chnl_err,
    input  logic [2:0]       rd_chnl,
    output logic [RES_W-1:0] rd_res
);

    localparam logic [3:0] NUM_CHNL_W = 4'(NUM_CHNL);

    state_t                 state_reg, state_next;
    logic [2:0]             cur_ch_reg, cur_ch_next;
    logic [1:0]             gap_cnt_reg, gap_cnt_next;
    logic                   chnl_err_reg, chnl_err_next;
    logic                   cnv_cmplt_reg;
    logic [RES_W-1:0]       res_reg;
    logic [2:0]             res_chnl_reg;
    logic [RES_W-1:0]       bank [NUM_CHNL];

    logic                   wrt;
    logic [2:0]             xfer_ch;
    logic                   load_res;
    logic                   xfer_done;
    logic [SPI_FRAME_W-1:0] rd_data;
    logic [RES_W-1:0]       res_new;

    assign res_new = rd_data[11 -: RES_W];

`ifdef A2D_SCAN_EN
    logic [2:0] ptr_reg, ptr_next, ptr_inc;
    assign ptr_inc = (ptr_reg == 3'(NUM_CHNL - 1)) ? 3'd0 : ptr_reg + 3'd1;
`else
    logic unused_scan_en;
    assign unused_scan_en = scan_en;
`endif

    logic unused_rd_data;
    assign unused_rd_data = ^rd_data;

    a2d_spi_xfer #(
        .SCLK_DIV (SCLK_DIV)
    ) u_xfer (
        .clk     (clk),
        .rst_n   (rst_n),
        .wrt     (wrt),
        .cmd     (build_cmd(xfer_ch)),
        .MISO    (MISO),
        .SS_n    (a2d_SS_n),
        .SCLK    (SCLK),
        .MOSI    (MOSI),
        .done    (xfer_done),
        .rd_data (rd_data)
    );

    // Next-state logic: request arbitration, frame sequencing, result load
    always_comb begin
        state_next    = state_reg;
        cur_ch_next   = cur_ch_reg;
        gap_cnt_next  = gap_cnt_reg;
        chnl_err_next = 1'b0;
        wrt           = 1'b0;
        load_res      = 1'b0;
        xfer_ch       = cur_ch_reg;
`ifdef A2D_SCAN_EN
        ptr_next      = ptr_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (strt_cnv) begin
                    if ({1'b0, chnnl} < NUM_CHNL_W) begin
                        wrt         = 1'b1;
                        xfer_ch     = chnnl;
                        cur_ch_next = chnnl;
                        state_next  = CMD;
                    end else begin
                        chnl_err_next = 1'b1;
                    end
                end
`ifdef A2D_SCAN_EN
                else if (scan_en) begin
                    wrt         = 1'b1;
                    xfer_ch     = ptr_reg;
                    cur_ch_next = ptr_reg;
                    ptr_next    = ptr_inc;
                    state_next  = CMD;
                end
`endif
            end
            CMD: begin
                if (xfer_done) begin
                    gap_cnt_next = 2'd0;
                    state_next   = GAP;
                end
            end
            GAP: begin
                // SS_n already rose on the GAP entry edge; count out the gap
                if (gap_cnt_reg == 2'(GAP_CYC - 1)) begin
                    wrt        = 1'b1;
                    state_next = RD;
                end else begin
                    gap_cnt_next = gap_cnt_reg + 2'd1;
                end
            end
            RD: begin
                if (xfer_done)
                    state_next = DONE;
            end
            DONE: begin
                load_res   = 1'b1;
                state_next = IDLE;
`ifdef A2D_SCAN_EN
                // Continue scanning without an IDLE bubble
                if (scan_en) begin
                    wrt         = 1'b1;
                    xfer_ch     = ptr_reg;
                    cur_ch_next = ptr_reg;
                    ptr_next    = ptr_inc;
                    state_next  = CMD;
                end
`endif
            end
            default: state_next = IDLE;
        endcase
    end

    // Control and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            cur_ch_reg    <= '0;
            gap_cnt_reg   <= '0;
            chnl_err_reg  <= 1'b0;
            cnv_cmplt_reg <= 1'b0;
            res_reg       <= '0;
            res_chnl_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            cur_ch_reg    <= cur_ch_next;
            gap_cnt_reg   <= gap_cnt_next;
            chnl_err_reg  <= chnl_err_next;
            cnv_cmplt_reg <= load_res;
            if (load_res) begin
                res_reg      <= res_new;
                res_chnl_reg <= cur_ch_reg;
            end
        end
    end

`ifdef A2D_SCAN_EN
    // Round-robin scan pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ptr_reg <= '0;
        else
            ptr_reg <= ptr_next;
    end
`endif

    // Per-channel result bank, written at conversion completion
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CHNL; i++)
                bank[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_CHNL; i++)
                if (load_res && (cur_ch_reg == 3'(i)))
                    bank[i] <= res_new;
        end
    end

    // Asynchronous bank read; out-of-range index reads zero
    always_comb begin
        rd_res = '0;
        for (int i = 0; i < NUM_CHNL; i++)
            if (rd_chnl == 3'(i))
                rd_res = bank[i];
    end

    assign busy      = (state_reg != IDLE) || cnv_cmplt_reg;
    assign cnv_cmplt = cnv_cmplt_reg;
    assign res       = res_reg;
    assign res_chnl  = res_chnl_reg;
    assign chnl_err  = chnl_err_reg;

endmodule

// File: tb/tb_a2d_scan_intf.sv
// Directed bench for a2d_scan_intf: default-parameter instance (u1) plus a
// small instance (u2: NUM_CHNL=3, RES_W=8, SCLK_DIV=4). Each has an SPI A2D
// model. Scan checks are built when A2D_SCAN_EN is defined.
`timescale 1ns/1ps
module tb_a2d_scan_intf;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // u1 signals (defaults)
    logic        strt1 = 1'b0, scan1 = 1'b0, miso1 = 1'b0;
    logic [2:0]  ch1 = 3'd0, rdc1 = 3'd0, rch1;
    logic        ss1, sclk1, mosi1, busy1, cmp1, err1;
    logic [11:0] res1, rdres1;

    // u2 signals
    logic        strt2 = 1'b0, scan2 = 1'b0, miso2 = 1'b0;
    logic [2:0]  ch2 = 3'd0, rdc2 = 3'd0, rch2;
    logic        ss2, sclk2, mosi2, busy2, cmp2, err2;
    logic [7:0]  res2, rdres2;

    int vectors = 0;
    int miscompares = 0;

    a2d_scan_intf u1 (
        .clk(clk), .rst_n(rst_n), .strt_cnv(strt1), .chnnl(ch1), .scan_en(scan1),
        .MISO(miso1), .a2d_SS_n(ss1), .SCLK(sclk1), .MOSI(mosi1), .busy(busy1),
        .cnv_cmplt(cmp1), .res(res1), .res_chnl(rch1), .chnl_err(err1),
        .rd_chnl(rdc1), .rd_res(rdres1)
    );

    a2d_scan_intf #(.NUM_CHNL(3), .RES_W(8), .SCLK_DIV(4)) u2 (
        .clk(clk), .rst_n(rst_n), .strt_cnv(strt2), .chnnl(ch2), .scan_en(scan2),
        .MISO(miso2), .a2d_SS_n(ss2), .SCLK(sclk2), .MOSI(mosi2), .busy(busy2),
        .cnv_cmplt(cmp2), .res(res2), .res_chnl(rch2), .chnl_err(err2),
        .rd_chnl(rdc2), .rd_res(rdres2)
    );

    // ---------------- A2D model for u1: always returns 0x0ABC ----------------
    int          rise1 = 0, frames1 = 0, cmpcnt1 = 0;
    logic [15:0] msh1 = '0, last1 = '0, prev1 = '0;
    logic [15:0] word1 = 16'h0ABC;

    always @(posedge sclk1 or posedge ss1) begin
        if (ss1 === 1'b1) begin
            if (rise1 > 0) begin
                prev1 = last1;
                last1 = msh1;
                frames1++;
            end
            rise1 = 0;
        end else begin
            msh1 = {msh1[14:0], mosi1};
            rise1++;
        end
    end

    always @(negedge sclk1 or negedge ss1)
        if (ss1 === 1'b0 && rise1 < 16) miso1 = word1[15 - rise1];

    always @(negedge clk) if (cmp1 === 1'b1) cmpcnt1++;

    // ---------------- A2D model for u2 ----------------
    // Returns 0x0ABC in fixed mode, else 0x0A0C | (ch << 4) where ch is the
    // channel of the previous command frame.
    int          rise2 = 0, frames2 = 0;
    logic [15:0] msh2 = '0, last2 = '0;
    logic        m2_fixed = 1'b1;
    logic [15:0] word2;

    always @(posedge sclk2 or posedge ss2) begin
        if (ss2 === 1'b1) begin
            if (rise2 > 0) begin
                last2 = msh2;
                frames2++;
            end
            rise2 = 0;
        end else begin
            msh2 = {msh2[14:0], mosi2};
            rise2++;
        end
    end

    always @(negedge sclk2 or negedge ss2) begin
        word2 = m2_fixed ? 16'h0ABC : (16'h0A0C | {9'b0, last2[13:11], 4'b0});
        if (ss2 === 1'b0 && rise2 < 16) miso2 = word2[15 - rise2];
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Tick until u1/u2 cnv_cmplt is seen or the bound expires; returns edges
    task automatic wait_cmp(input int which, input int limit, output int k);
        k = 0;
        do begin
            tick();
            k++;
        end while (!((which == 1) ? cmp1 : cmp2) && k < limit);
    endtask

    int k;
    logic [2:0] exp_ch;

    initial begin
        // ---- reset state ----
        repeat (3) @(posedge clk);
        #1;
        check("rst_ss_n", ss1, 1);
        check("rst_sclk", sclk1, 1);
        check("rst_mosi", mosi1, 0);
        check("rst_busy", busy1, 0);
        check("rst_cmplt", cmp1, 0);
        check("rst_res", res1, 0);
        check("rst_res_chnl", rch1, 0);
        check("rst_chnl_err", err1, 0);
        check("rst_rd_res", rdres1, 0);
        #2 rst_n = 1'b1;
        tick(); tick();

        // ---- u1 single conversion, ch3, with an ignored re-request ----
        @(negedge clk); strt1 = 1'b1; ch1 = 3'd3;
        @(posedge clk); #1; strt1 = 1'b0;
        check("start_ss_n_low", ss1, 0);
        check("start_busy", busy1, 1);
        k = 1;
        while (!cmp1 && k < 1200) begin
            tick();
            k++;
            if (k == 100) begin strt1 = 1'b1; ch1 = 3'd5; end
            if (k == 101) strt1 = 1'b0;
        end
        k--;
        check("u1_latency", k, 1059);
        check("u1_res", res1, 12'hABC);
        check("u1_res_chnl", rch1, 3);
        check("u1_busy_at_cmplt", busy1, 1);
        check("u1_frame1_mosi", prev1, 16'h1800);
        check("u1_frame2_mosi", last1, 16'h1800);
        check("u1_frames", frames1, 2);
        rdc1 = 3'd3; #1;
        check("u1_bank3", rdres1, 12'hABC);
        rdc1 = 3'd2; #1;
        check("u1_bank2", rdres1, 0);
        tick();
        check("u1_cmplt_pulse", cmp1, 0);
        check("u1_busy_fall", busy1, 0);
        repeat (60) tick();
        check("u1_one_cmplt", cmpcnt1, 1);
        check("u1_no_extra_frame", frames1, 2);

        // ---- u2 invalid channels ----
        @(negedge clk); strt2 = 1'b1; ch2 = 3'd7;
        @(posedge clk); #1; strt2 = 1'b0;
        check("err7_pulse", err2, 1);
        check("err7_busy", busy2, 0);
        check("err7_ss_n", ss2, 1);
        tick();
        check("err7_pulse_end", err2, 0);
        @(negedge clk); strt2 = 1'b1; ch2 = 3'd3;
        @(posedge clk); #1; strt2 = 1'b0;
        check("err3_pulse", err2, 1);
        repeat (20) tick();
        check("err_no_frames", frames2, 0);

        // ---- u2 single conversion, RES_W=8 truncation ----
        @(negedge clk); strt2 = 1'b1; ch2 = 3'd1;
        @(posedge clk); #1; strt2 = 1'b0;
        wait_cmp(2, 300, k);
        check("u2_latency", k, 135);
        check("u2_res_trunc", res2, 8'hAB);
        check("u2_res_chnl", rch2, 1);
        rdc2 = 3'd1; #1;
        check("u2_bank1", rdres2, 8'hAB);
        rdc2 = 3'd0; #1;
        check("u2_bank0_untouched", rdres2, 0);

`ifdef A2D_SCAN_EN
        // ---- u2 round-robin scan: 0,1,2,0 then 1 after scan_en drops ----
        m2_fixed = 1'b0;
        @(negedge clk); scan2 = 1'b1;
        exp_ch = 3'd0;
        for (int n = 0; n < 5; n++) begin
            wait_cmp(2, 300, k);
            check("scan_res_chnl", rch2, exp_ch);
            check("scan_res", res2, 8'hA0 | {5'b0, exp_ch});
            if (n > 0) check("scan_period", k, 135);
            if (n < 4) check("scan_back_to_back", ss2, 0);
            if (n == 3) scan2 = 1'b0;
            exp_ch = (exp_ch == 3'd2) ? 3'd0 : exp_ch + 3'd1;
        end
        repeat (20) tick();
        check("scan_stop_ss_n", ss2, 1);
        check("scan_stop_busy", busy2, 0);
        rdc2 = 3'd0; #1; check("scan_bank0", rdres2, 8'hA0);
        rdc2 = 3'd1; #1; check("scan_bank1", rdres2, 8'hA1);
        rdc2 = 3'd2; #1; check("scan_bank2", rdres2, 8'hA2);
        rdc2 = 3'd3; #1; check("scan_bank3_oob", rdres2, 0);
`else
        // ---- scan disabled: scan_en must be ignored ----
        @(negedge clk); scan2 = 1'b1;
        repeat (200) tick();
        check("noscan_frames", frames2, 2);
        check("noscan_busy", busy2, 0);
        scan2 = 1'b0;
`endif
        rdc2 = 3'd7; #1; check("u2_bank7_oob", rdres2, 0);

        // ---- asynchronous reset mid-frame on u1 ----
        @(negedge clk); strt1 = 1'b1; ch1 = 3'd5;
        @(posedge clk); #1; strt1 = 1'b0;
        repeat (200) tick();
        check("mid_frame_ss_n", ss1, 0);
        #3 rst_n = 1'b0;
        #1;
        check("arst_ss_n", ss1, 1);
        check("arst_sclk", sclk1, 1);
        check("arst_busy", busy1, 0);
        check("arst_res", res1, 0);
        check("arst_res_chnl", rch1, 0);
        rdc1 = 3'd3; #1; check("arst_u1_bank3", rdres1, 0);
        rdc2 = 3'd1; #1; check("arst_u2_bank1", rdres2, 0);
        check("arst_u2_res", res2, 0);
        @(negedge clk); rst_n = 1'b1;
        tick(); tick();

        // ---- normal conversion after reset, ch2 ----
        @(negedge clk); strt1 = 1'b1; ch1 = 3'd2;
        @(posedge clk); #1; strt1 = 1'b0;
        wait_cmp(1, 1200, k);
        check("post_rst_latency", k, 1059);
        check("post_rst_res", res1, 12'hABC);
        check("post_rst_res_chnl", rch1, 2);
        check("post_rst_frame1", prev1, 16'h1000);
        check("post_rst_frame2", last1, 16'h1000);
        rdc1 = 3'd2; #1; check("post_rst_bank2", rdres1, 12'hABC);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
